simd_conv_ctrl: RTL and testbench
=================================

Name: simd_conv_ctrl

Overview:
Sequencer for a lane array of SIMD multiply-accumulate PEs with Q8.8 operands, shared pixel broadcast, per-lane weights and a ReLU-clamped output.
- Steps the array through a batch of convolution windows of KSIZE taps each.
- Issues synchronous-read addresses to the pixel buffer (window-major, pre-flattened taps) and the weight memory (one LANES-wide word per tap).
- Drives the array's clear-accumulator and MAC-enable strobes aligned to read-data latency.
- Presents each finished window's lane results behind a valid/ready handshake.

Parameters:
KSIZE, 9, taps per window (>=1)
ADDR_W, 12, pixel buffer address width
WADDR_W, 4, weight memory address width (2^WADDR_W >= KSIZE)
WIN_W, 10, window count width
RD_LAT, 1, read latency of both memories in cycles (fixed; only 1 supported)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin batch; sampled only in IDLE
num_win  in  WIN_W  windows in batch; latched on accepted start
pix_base  in  ADDR_W  pixel address of window 0 tap 0; latched on accepted start
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse at batch end
pix_rd_en  out  1  pixel buffer read enable
pix_addr  out  ADDR_W  pixel read address
wgt_rd_en  out  1  weight memory read enable (same timing as pix_rd_en)
wgt_addr  out  WADDR_W  weight read address = tap index
clr_acc  out  1  to all PEs: clear accumulators
en_mac  out  1  to all PEs: accumulate current pixel*weight
res_valid  out  1  PE results are final for window res_win
res_ready  in  1  consumer has taken results
res_win  out  WIN_W  index of window currently in RESULT

Behaviour:
- Reset values: all outputs 0. State is IDLE; counters and pointers are 0.
- Reset mid-operation aborts immediately. No done pulse is produced.
- All outputs are registered.
- States: IDLE, CLEAR, MAC, DRAIN, RESULT, DONE.
- IDLE: on start=1:
  - num_win==0: go to DONE.
  - Otherwise: latch num_win; load ptr<=pix_base, win<=0; go to CLEAR.
  - start outside IDLE is ignored with no side effects.
- CLEAR (1 cycle):
  - clr_acc=1.
  - Issue tap 0: rd_en=1, pix_addr=ptr, wgt_addr=0. Then ptr++, tap<=1.
  - Next state: MAC if KSIZE>1, else DRAIN.
- MAC (KSIZE-1 cycles):
  - Each cycle issues tap t: pix_addr=ptr, wgt_addr=t. Then ptr++, tap++.
  - After issuing tap KSIZE-1, go to DRAIN.
- en_mac is the issue strobe delayed by RD_LAT. It is high in the cycle the read data is on the PE inputs: the first MAC cycle through the DRAIN cycle, exactly KSIZE cycles per window.
- clr_acc and en_mac are never high in the same cycle.
- DRAIN (1 cycle): no issue. The last tap's en_mac is high. Go to RESULT.
- RESULT:
  - res_valid=1 and res_win=win. en_mac=0 and clr_acc=0, so results stay stable.
  - Hold while res_ready=0; res_valid stays high with no timeout.
  - On res_valid&&res_ready: if win==num_win-1 go to DONE, else win++ and go to CLEAR.
  - ptr continues linearly, so window w starts at pix_base+w*KSIZE.
- DONE (1 cycle): done=1, busy=1. Next cycle: IDLE, busy=0.
- Minimum per-window period with res_ready held high: KSIZE+2 cycles (CLEAR + MAC×(KSIZE-1) + DRAIN + RESULT).
- Address arithmetic is modulo 2^ADDR_W. ptr wraps silently from all-ones to 0.
- The tap counter never exceeds KSIZE-1.
- No multiplier in the address path; ptr is a running incrementer.

Decomposition:
- Shared package simd_pkg holds:
  - state enum (IDLE, CLEAR, MAC, DRAIN, RESULT, DONE)
  - Q8.8 constants: DATA_W=16, FRAC_BITS=8, ACC_W=32
  - default KSIZE and LANES
- Single module; no sub-module is warranted. The read-latency delay is one flop inside this module.

Test Plan:
- KSIZE=9, num_win=1, pix_base=0x010, res_ready=1:
  - pix_addr sequence 0x010..0x018 and wgt_addr 0..8 on consecutive cycles.
  - clr_acc one cycle, then en_mac exactly 9 cycles.
  - res_valid 1 cycle, res_win=0, done 11 cycles after start.
  - With PE model, all pixels 0x0100 and weights 0x0100 → every lane result 0x0900.
- num_win=3, res_ready low for 5 cycles in window 1:
  - res_valid held 6 cycles, no issue/en_mac meanwhile.
  - Window 2 starts at pix_base+18.
  - Exactly one done pulse.
- start with num_win=0: done pulse the cycle after IDLE exit; zero rd_en/clr_acc/en_mac cycles.
- start pulses during busy: ignored; address sequence and done timing identical to an undisturbed run.
- rst_n low during MAC tap 4: all outputs 0 asynchronously; IDLE after release; next start runs cleanly from window 0.
- pix_base=2^ADDR_W-4, KSIZE=9: addresses wrap to 0 after all-ones and continue to 4.
- KSIZE=1: CLEAR→DRAIN, one en_mac per window, period 3 cycles.

Source files
------------

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared state encodings and Q8.8 datapath constants for the SIMD conv array
package simd_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_MAC    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 32;

    localparam int DEF_KSIZE = 9;
    localparam int DEF_LANES = 4;

endpackage

// File: rtl/simd_conv_ctrl.sv
// rtl/simd_conv_ctrl.sv - window sequencer issuing pixel/weight reads and PE strobes
module simd_conv_ctrl
    import simd_pkg::*;
#(
    parameter int KSIZE   = DEF_KSIZE,
    parameter int ADDR_W  = 12,
    parameter int WADDR_W = 4,
    parameter int WIN_W   = 10,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIN_W-1:0]   num_win,
    input  logic [ADDR_W-1:0]  pix_base,
    output logic               busy,
    output logic               done,
    output logic               pix_rd_en,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               wgt_rd_en,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               clr_acc,
    output logic               en_mac,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIN_W-1:0]   res_win
);

    localparam logic [WADDR_W-1:0] LAST_TAP = WADDR_W'(KSIZE - 1);

    logic [2:0]        state;
    logic [WIN_W-1:0]  nwin;
    logic [WIN_W-1:0]  win;
    logic [RD_LAT-1:0] mac_pipe;

    // pix_addr doubles as the running pointer and wgt_addr as the tap counter:
    // each registered issue is the previous issue plus one.
    assign en_mac  = mac_pipe[RD_LAT-1];
    assign res_win = win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_rd_en <= 1'b0;
            wgt_rd_en <= 1'b0;
            pix_addr  <= '0;
            wgt_addr  <= '0;
            clr_acc   <= 1'b0;
            res_valid <= 1'b0;
            nwin      <= '0;
            win       <= '0;
            mac_pipe  <= '0;
        end else begin
            mac_pipe  <= (mac_pipe << 1) | RD_LAT'(pix_rd_en);
            done      <= 1'b0;
            clr_acc   <= 1'b0;
            pix_rd_en <= 1'b0;
            wgt_rd_en <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_win == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_CLEAR;
                            nwin      <= num_win;
                            win       <= '0;
                            pix_addr  <= pix_base;
                            wgt_addr  <= '0;
                            pix_rd_en <= 1'b1;
                            wgt_rd_en <= 1'b1;
                            clr_acc   <= 1'b1;
                        end
                    end
                end
                ST_CLEAR, ST_MAC: begin
                    if (wgt_addr == LAST_TAP) begin
                        state <= ST_DRAIN;
                    end else begin
                        state     <= ST_MAC;
                        pix_addr  <= pix_addr + 1'b1;
                        wgt_addr  <= wgt_addr + 1'b1;
                        pix_rd_en <= 1'b1;
                        wgt_rd_en <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_RESULT;
                    res_valid <= 1'b1;
                end
                ST_RESULT: begin
                    if (!res_ready) begin
                        res_valid <= 1'b1;
                    end else if (win == nwin - 1'b1) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        // next window continues straight on from the last tap address
                        state     <= ST_CLEAR;
                        win       <= win + 1'b1;
                        pix_addr  <= pix_addr + 1'b1;
                        wgt_addr  <= '0;
                        pix_rd_en <= 1'b1;
                        wgt_rd_en <= 1'b1;
                        clr_acc   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_conv_ctrl.sv
// tb/tb_simd_conv_ctrl.sv - directed table-driven bench for simd_conv_ctrl with a Q8.8 PE lane model
module tb_simd_conv_ctrl;
    import simd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  num_win = '0;
    logic [11:0] pix_base = '0;
    logic        res_ready = 1'b1;
    int          sel = 0;

    logic        b0, d0, rd0, wr0, c0, e0, v0;
    logic [11:0] a0;
    logic [3:0]  wa0;
    logic [9:0]  w0;
    logic        b1, d1, rd1, wr1, c1, e1, v1;
    logic [11:0] a1;
    logic [3:0]  wa1;
    logic [9:0]  w1;

    logic        m_busy, m_done, m_rd, m_wrd, m_clr, m_en, m_rv;
    logic [11:0] m_addr;
    logic [3:0]  m_wgt;
    logic [9:0]  m_win;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simd_conv_ctrl #(.KSIZE(9)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .num_win(num_win), .pix_base(pix_base),
        .busy(b0), .done(d0), .pix_rd_en(rd0), .pix_addr(a0), .wgt_rd_en(wr0), .wgt_addr(wa0),
        .clr_acc(c0), .en_mac(e0), .res_valid(v0), .res_ready(res_ready), .res_win(w0)
    );

    simd_conv_ctrl #(.KSIZE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .num_win(num_win), .pix_base(pix_base),
        .busy(b1), .done(d1), .pix_rd_en(rd1), .pix_addr(a1), .wgt_rd_en(wr1), .wgt_addr(wa1),
        .clr_acc(c1), .en_mac(e1), .res_valid(v1), .res_ready(res_ready), .res_win(w1)
    );

    always_comb begin
        m_busy = sel == 1 ? b1  : b0;
        m_done = sel == 1 ? d1  : d0;
        m_rd   = sel == 1 ? rd1 : rd0;
        m_wrd  = sel == 1 ? wr1 : wr0;
        m_clr  = sel == 1 ? c1  : c0;
        m_en   = sel == 1 ? e1  : e0;
        m_rv   = sel == 1 ? v1  : v0;
        m_addr = sel == 1 ? a1  : a0;
        m_wgt  = sel == 1 ? wa1 : wa0;
        m_win  = sel == 1 ? w1  : w0;
    end

    // PE lanes: every pixel reads 1.0, lane l weight reads (l+1).0
    logic [DATA_W-1:0] pix_q;
    int wq [DEF_LANES];
    int acc [DEF_LANES];
    always @(posedge clk) begin
        pix_q <= m_rd ? 16'h0100 : 16'h0000;
        for (int l = 0; l < DEF_LANES; l++) begin
            wq[l] <= m_wrd ? (l + 1) * 256 : 0;
            if (m_clr) acc[l] <= 0;
            else if (m_en) acc[l] <= acc[l] + ((int'(pix_q) * wq[l]) >>> FRAC_BITS);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sel; int ks; int nw; int base; int stall_win; int stall_len; int noise;
        int exp_done; int exp_rv; int exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic run_row(input int r, input vec_t v);
        int done_cyc = -1, rd_n = 0, en_n = 0, clr_n = 0, rv_n = 0, acc_n = 0;
        int addr_err = 0, ovl_err = 0, busy_err = 0, pe_err = 0, win_err = 0;
        int issue = 0, stalled = 0, last = -1, extra = 0;
        sel = v.sel; num_win = 10'(v.nw); pix_base = 12'(v.base); res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (m_rd) begin
                rd_n++;
                if (int'(m_addr) != (v.base + issue) % 4096) addr_err++;
                if (int'(m_wgt) != issue % v.ks) addr_err++;
                last = int'(m_addr);
                issue++;
            end
            if (m_rd != m_wrd) addr_err++;
            if (m_en) en_n++;
            if (m_clr) clr_n++;
            if (m_clr && m_en) ovl_err++;
            if (m_rv && (m_rd || m_en || m_clr)) ovl_err++;
            if (!m_busy) busy_err++;
            res_ready = 1'b1;
            if (m_rv) begin
                rv_n++;
                if (int'(m_win) == v.stall_win && stalled < v.stall_len) begin
                    res_ready = 1'b0;
                    stalled++;
                end else begin
                    if (int'(m_win) != acc_n) win_err++;
                    for (int l = 0; l < DEF_LANES; l++)
                        if (acc[l] != v.ks * (l + 1) * 256) pe_err++;
                    acc_n++;
                end
            end
            start    = v.noise != 0 && c % 5 == 2;
            num_win  = start ? 10'd0 : 10'(v.nw);
            pix_base = start ? 12'h555 : 12'(v.base);
            if (m_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; num_win = 10'(v.nw); pix_base = 12'(v.base); res_ready = 1'b1;
        check($sformatf("r%0d_done_cycle", r), done_cyc, v.exp_done);
        check($sformatf("r%0d_rd_cycles", r), rd_n, v.nw * v.ks);
        check($sformatf("r%0d_en_mac_cycles", r), en_n, v.nw * v.ks);
        check($sformatf("r%0d_clr_cycles", r), clr_n, v.nw);
        check($sformatf("r%0d_res_valid_cycles", r), rv_n, v.exp_rv);
        check($sformatf("r%0d_results_taken", r), acc_n, v.nw);
        check($sformatf("r%0d_last_addr", r), last, v.exp_last);
        check($sformatf("r%0d_addr_errs", r), addr_err, 0);
        check($sformatf("r%0d_overlap_errs", r), ovl_err, 0);
        check($sformatf("r%0d_busy_errs", r), busy_err, 0);
        check($sformatf("r%0d_lane_errs", r), pe_err, 0);
        check($sformatf("r%0d_res_win_errs", r), win_err, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_done) extra++;
        end
        check($sformatf("r%0d_extra_done", r), extra, 0);
        check($sformatf("r%0d_busy_after", r), int'(m_busy), 0);
    endtask

    initial begin
        int found;
        //         sel ks nw base    swin slen noise done rv last
        vecs[0] = '{0, 9, 1, 'h010, -1,  0,   0,    11,  1, 'h018};
        vecs[1] = '{0, 9, 3, 'h100,  1,  5,   0,    38,  8, 'h11A};
        vecs[2] = '{0, 9, 0, 'h123, -1,  0,   0,     0,  0, -1};
        vecs[3] = '{0, 9, 2, 'hFFC, -1,  0,   0,    22,  2, 'h00D};
        vecs[4] = '{0, 9, 3, 'h100, -1,  0,   1,    33,  3, 'h11A};
        vecs[5] = '{1, 1, 3, 'h020, -1,  0,   0,     9,  3, 'h022};
        vecs[6] = '{1, 1, 1, 'hFFF,  0,  2,   0,     5,  3, 'hFFF};

        repeat (3) @(negedge clk);
        check("reset_u0_outputs", int'(|{b0, d0, rd0, a0, wr0, wa0, c0, e0, v0, w0}), 0);
        check("reset_u1_outputs", int'(|{b1, d1, rd1, a1, wr1, wa1, c1, e1, v1, w1}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 7; r++) run_row(r, vecs[r]);

        // abort mid-window at tap 4, then a clean rerun from window 0
        sel = 0; num_win = 10'd2; pix_base = 12'h040;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (m_rd && m_wgt == 4'd4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_tap4", found, 1);
        check("rst_tap4_addr", int'(m_addr), 'h044);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", int'(|{b0, d0, rd0, a0, wr0, wa0, c0, e0, v0, w0}), 0);
        repeat (2) @(negedge clk);
        check("rst_no_done", int'(d0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle_after", int'(|{b0, d0, rd0, v0}), 0);
        run_row(7, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
